// File: rtl/counter_pkg.sv
// Shared types, limits and elaboration helpers for the modulo counter family.
package counter_pkg;

   localparam int MAX_WIDTH = 32;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   // True when the modulus fits the register width and has at least two states.
   function automatic bit legal_modulus(input int width, input longint modulus);
      bit ok;
      if ((width < 1) || (width > MAX_WIDTH)) begin
         ok = 1'b0;
      end else begin
         ok = (modulus >= 64'sd2) && (modulus <= (64'sd1 <<< width));
      end
      return ok;
   endfunction

endpackage

// File: rtl/mod_next_val.sv
// Combinational next-value logic for one modulo counter stage.
// Arithmetic is carried in WIDTH+1 bits so a full 2**WIDTH modulus cannot overflow.
// Build option: MOD_COUNTER_SAT_EN selects saturate-at-bound instead of wrap-around.
module mod_next_val
   import counter_pkg::*;
#(
   parameter int     WIDTH   = 4,
   parameter longint MODULUS = 10
) (
   input  logic [WIDTH-1:0] count,
   input  dir_e             dir,
   input  logic             at_term,
   output logic [WIDTH-1:0] next_count,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'sd1);

   logic [WIDTH:0] count_ext;
   logic [WIDTH:0] inc_ext;
   logic [WIDTH:0] dec_ext;

   assign count_ext = {1'b0, count};
   assign inc_ext   = count_ext + {{WIDTH{1'b0}}, 1'b1};
   assign dec_ext   = count_ext - {{WIDTH{1'b0}}, 1'b1};

`ifdef MOD_COUNTER_SAT_EN
   // Saturating step: hold at the bound, flag only the step that first lands on it.
   always_comb begin
      next_count = count;
      wrap       = 1'b0;
      if (at_term) begin
         next_count = count;
         wrap       = 1'b0;
      end else if (dir == DIR_UP) begin
         next_count = WIDTH'(inc_ext);
         wrap       = (WIDTH'(inc_ext) == MAX_VAL);
      end else begin
         next_count = WIDTH'(dec_ext);
         wrap       = (WIDTH'(dec_ext) == {WIDTH{1'b0}});
      end
   end
`else
   // Wrapping step: at the terminal value jump to the opposite end and flag the wrap.
   always_comb begin
      next_count = count;
      wrap       = 1'b0;
      if (at_term) begin
         wrap       = 1'b1;
         next_count = (dir == DIR_UP) ? {WIDTH{1'b0}} : MAX_VAL;
      end else if (dir == DIR_UP) begin
         next_count = WIDTH'(inc_ext);
         wrap       = 1'b0;
      end else begin
         next_count = WIDTH'(dec_ext);
         wrap       = 1'b0;
      end
   end
`endif

endmodule

// File: rtl/mod_updown_counter.sv
// Up/down modulo counter stage with parallel load, enable and a synchronous cascade chain.
// Stages chain en_out -> en_in so a multi-digit counter advances on a single edge.
// Build option: MOD_COUNTER_SAT_EN makes the stage saturate and disables cascade output.
module mod_updown_counter
   import counter_pkg::*;
#(
   parameter int     WIDTH     = 4,
   parameter longint MODULUS   = 10,
   parameter longint RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_in,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             at_term,
   output logic             en_out,
   output logic             tc
);

   localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 64'sd1);
   localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);

   if (!legal_modulus(WIDTH, MODULUS)) begin : g_bad_modulus
      $fatal(1, "mod_updown_counter: MODULUS must lie in 2..2**WIDTH and WIDTH in 1..32");
   end

   if ((RESET_VAL < 64'sd0) || (RESET_VAL >= MODULUS)) begin : g_bad_reset_val
      $fatal(1, "mod_updown_counter: RESET_VAL must be below MODULUS");
   end

   dir_e             dir;
   logic [WIDTH-1:0] next_count;
   logic             wrap;
   logic [63:0]      load_ext;
   logic [WIDTH-1:0] load_clamped;

   assign dir = dir_e'(up_dn);

   assign at_term = (dir == DIR_UP) ? (count == MAX_VAL) : (count == {WIDTH{1'b0}});

`ifdef MOD_COUNTER_SAT_EN
   assign en_out = 1'b0;
`else
   assign en_out = en_in & at_term & ~load;
`endif

   // Out-of-range load values are clamped to the top state rather than aliased.
   assign load_ext     = 64'(load_val);
   assign load_clamped = (load_ext >= 64'(MODULUS)) ? MAX_VAL : load_val;

   mod_next_val #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_next (
      .count      (count),
      .dir        (dir),
      .at_term    (at_term),
      .next_count (next_count),
      .wrap       (wrap)
   );

   // Count and terminal-count registers: reset, then load, then enabled step, else hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= RST_COUNT;
         tc    <= 1'b0;
      end else if (load) begin
         count <= load_clamped;
         tc    <= 1'b0;
      end else if (en_in) begin
         count <= next_count;
         tc    <= wrap;
      end else begin
         count <= count;
         tc    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: a units/tens cascade (MODULUS 10), a full-range
// stage (MODULUS 16) and a toggle stage (WIDTH 1), all checked every cycle against a
// arithmetic reference model, plus literal spot checks. Honours MOD_COUNTER_SAT_EN.
module tb_mod_updown_counter;

`ifdef MOD_COUNTER_SAT_EN
   localparam bit SAT = 1'b1;
   localparam int E_A_C0 = 9, E_A_T0 = 0, E_A_C1 = 0;
   localparam int E_B_C0 = 9;
   localparam int E_C_C0 = 0, E_C_T0 = 0;
   localparam int E_D_C0 = 0, E_D_C1 = 0;
   localparam int E_E_C0 = 9, E_E_C1 = 0, E_E_C2 = 15, E_E_C3 = 1;
   localparam int E_F_C0 = 6, E_G_C0 = 7;
`else
   localparam bit SAT = 1'b0;
   localparam int E_A_C0 = 0, E_A_T0 = 1, E_A_C1 = 1;
   localparam int E_B_C0 = 2;
   localparam int E_C_C0 = 9, E_C_T0 = 1;
   localparam int E_D_C0 = 8, E_D_C1 = 0;
   localparam int E_E_C0 = 5, E_E_C1 = 2, E_E_C2 = 9, E_E_C3 = 1;
   localparam int E_F_C0 = 2, E_G_C0 = 3;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en_in = 1'b0;
   logic       up_dn = 1'b1;
   logic       load = 1'b0;
   logic [3:0] load_val = 4'd0;

   logic [3:0] cnt0, cnt1, cnt2;
   logic [0:0] cnt3;
   logic       at0, at1, at2, at3;
   logic       eo0, eo1, eo2, eo3;
   logic       tc0, tc1, tc2, tc3;

   int  n_vec = 0;
   int  n_mis = 0;
   bit  done = 1'b0;

   int  mods [4] = '{10, 10, 16, 2};
   int  m_cnt [4] = '{0, 0, 0, 0};
   int  m_tc [4] = '{0, 0, 0, 0};

   always #5 clk = ~clk;

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_units (
      .clk(clk), .rst(rst), .en_in(en_in), .up_dn(up_dn), .load(load), .load_val(load_val),
      .count(cnt0), .at_term(at0), .en_out(eo0), .tc(tc0));

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_tens (
      .clk(clk), .rst(rst), .en_in(eo0), .up_dn(up_dn), .load(1'b0), .load_val(4'd0),
      .count(cnt1), .at_term(at1), .en_out(eo1), .tc(tc1));

   mod_updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) u_full (
      .clk(clk), .rst(rst), .en_in(en_in), .up_dn(up_dn), .load(load), .load_val(load_val),
      .count(cnt2), .at_term(at2), .en_out(eo2), .tc(tc2));

   mod_updown_counter #(.WIDTH(1), .MODULUS(2), .RESET_VAL(0)) u_toggle (
      .clk(clk), .rst(rst), .en_in(en_in), .up_dn(up_dn), .load(load), .load_val(load_val[0:0]),
      .count(cnt3), .at_term(at3), .en_out(eo3), .tc(tc3));

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model terminal test from the current model count and direction.
   function automatic bit m_at(input int i);
      return up_dn ? (m_cnt[i] == mods[i] - 1) : (m_cnt[i] == 0);
   endfunction

   // Model cascade output: a stage at its terminal value passes its enable on unless loading.
   function automatic bit m_eo(input int i, input bit en, input bit ld);
      return SAT ? 1'b0 : (en & m_at(i) & ~ld);
   endfunction

   // One clock edge of the reference counter, in plain integer arithmetic.
   task automatic mstep(input int i, input bit en, input bit ud, input bit ld, input int lv);
      int m;
      m = mods[i];
      if (ld) begin
         m_cnt[i] = (lv >= m) ? m - 1 : lv;
         m_tc[i]  = 0;
      end else if (en) begin
         if (ud) begin
            if (m_cnt[i] == m - 1) begin
               if (SAT) m_tc[i] = 0;
               else begin m_cnt[i] = 0; m_tc[i] = 1; end
            end else begin
               m_cnt[i] = m_cnt[i] + 1;
               m_tc[i]  = (SAT && m_cnt[i] == m - 1) ? 1 : 0;
            end
         end else begin
            if (m_cnt[i] == 0) begin
               if (SAT) m_tc[i] = 0;
               else begin m_cnt[i] = m - 1; m_tc[i] = 1; end
            end else begin
               m_cnt[i] = m_cnt[i] - 1;
               m_tc[i]  = (SAT && m_cnt[i] == 0) ? 1 : 0;
            end
         end
      end else begin
         m_tc[i] = 0;
      end
   endtask

   // Reference model state update (reset acts immediately, like the DUT).
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            m_tc[i]  = 0;
         end
      end else begin
         bit en1;
         en1 = m_eo(0, en_in, load);
         mstep(0, en_in, up_dn, load, int'(load_val));
         mstep(1, en1, up_dn, 1'b0, 0);
         mstep(2, en_in, up_dn, load, int'(load_val));
         mstep(3, en_in, up_dn, load, int'(load_val[0]));
      end
   end

   // Every-cycle comparison of all DUT outputs against the model, mid-cycle.
   always @(negedge clk) begin
      if (!done) begin
         bit e1;
         e1 = m_eo(0, en_in, load);
         chk("u0.count", cnt0, m_cnt[0]);   chk("u0.tc", tc0, m_tc[0]);
         chk("u0.at_term", at0, m_at(0));   chk("u0.en_out", eo0, m_eo(0, en_in, load));
         chk("u1.count", cnt1, m_cnt[1]);   chk("u1.tc", tc1, m_tc[1]);
         chk("u1.at_term", at1, m_at(1));   chk("u1.en_out", eo1, m_eo(1, e1, 1'b0));
         chk("u2.count", cnt2, m_cnt[2]);   chk("u2.tc", tc2, m_tc[2]);
         chk("u2.at_term", at2, m_at(2));   chk("u2.en_out", eo2, m_eo(2, en_in, load));
         chk("u3.count", cnt3, m_cnt[3]);   chk("u3.tc", tc3, m_tc[3]);
         chk("u3.at_term", at3, m_at(3));   chk("u3.en_out", eo3, m_eo(3, en_in, load));
      end
   end

   task automatic apply(input bit e, input bit u, input bit l, input logic [3:0] v);
      en_in    = e;
      up_dn    = u;
      load     = l;
      load_val = v;
      @(posedge clk);
      #2;
   endtask

   initial begin
      repeat (3) apply(1'b0, 1'b1, 1'b0, 4'd0);
      rst = 1'b0;
      chk("reset_count", cnt0, 0);
      chk("reset_tc", tc0, 0);

      repeat (10) apply(1'b1, 1'b1, 1'b0, 4'd0);
      chk("up10_count", cnt0, E_A_C0);
      chk("up10_tc", tc0, E_A_T0);
      chk("up10_tens", cnt1, E_A_C1);
      repeat (2) apply(1'b1, 1'b1, 1'b0, 4'd0);
      chk("up12_count", cnt0, E_B_C0);
      chk("up12_tc", tc0, 0);

      apply(1'b0, 1'b0, 1'b1, 4'd2);
      chk("load2_count", cnt0, 2);
      repeat (3) apply(1'b1, 1'b0, 1'b0, 4'd0);
      chk("down3_count", cnt0, E_C_C0);
      chk("down3_tc", tc0, E_C_T0);
      apply(1'b1, 1'b0, 1'b0, 4'd0);
      chk("down4_count", cnt0, E_D_C0);
      chk("down4_tc", tc0, 0);
      chk("down4_tens", cnt1, E_D_C1);

      apply(1'b1, 1'b1, 1'b1, 4'd13);
      chk("clamp_count", cnt0, 9);
      chk("clamp_tc", tc0, 0);
      chk("clamp_full", cnt2, 13);
      apply(1'b1, 1'b1, 1'b1, 4'd5);
      chk("load5_count", cnt0, 5);
      apply(1'b0, 1'b1, 1'b1, 4'd7);
      chk("load7_count", cnt0, 7);

      rst = 1'b1;
      #1;
      chk("async_rst_count", cnt0, 0);
      chk("async_rst_tc", tc0, 0);
      chk("async_rst_full", cnt2, 0);
      apply(1'b0, 1'b1, 1'b0, 4'd0);
      rst = 1'b0;

      repeat (25) apply(1'b1, 1'b1, 1'b0, 4'd0);
      chk("cascade_units", cnt0, E_E_C0);
      chk("cascade_tens", cnt1, E_E_C1);
      chk("cascade_full", cnt2, E_E_C2);
      chk("cascade_toggle", cnt3, E_E_C3);

      repeat (3) apply(1'b1, 1'b0, 1'b0, 4'd0);
      chk("dirchg_down", cnt0, E_F_C0);
      apply(1'b1, 1'b1, 1'b0, 4'd0);
      chk("dirchg_up", cnt0, E_G_C0);
      repeat (2) apply(1'b0, 1'b1, 1'b0, 4'd0);
      chk("idle_hold", cnt0, E_G_C0);
      chk("idle_tc", tc0, 0);

      done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised synchronous up/down modulo counter with load, enable and a cascade chain.
- Replaces the hand-built ripple chains with one reusable counter stage.
- Instances chain through en_out/en_in to form multi-digit counters, such as BCD decades.
- Sits between stimulus/control logic and display or compare logic.

Parameters:
- WIDTH, 4, bit width of the count register; legal range 1..32.
- MODULUS, 10, number of states (count runs 0..MODULUS-1). Legal range 2..2**WIDTH. An illegal value is a fatal elaboration error.
- RESET_VAL, 0, value loaded by reset. Must be < MODULUS; otherwise fatal elaboration error.

Ports:
- clk  input  1  rising-edge clock, sole clock of the block
- rst  input  1  asynchronous, active-high reset
- en_in  input  1  count enable (cascade input from the lower stage; tie to 1 for the LSB stage)
- up_dn  input  1  1 = count up, 0 = count down; sampled only on enabled edges
- load  input  1  synchronous parallel load strobe
- load_val  input  WIDTH  value for load
- count  output  WIDTH  registered count value
- at_term  output  1  combinational: count is the terminal value for the current direction (MODULUS-1 when up, 0 when down)
- en_out  output  1  combinational cascade enable = en_in & at_term & ~load
- tc  output  1  registered terminal-count pulse

Behaviour:
- Reset (async assert, released synchronously by the environment):
  - count=RESET_VAL, tc=0.
  - at_term and en_out follow combinationally from count, up_dn and en_in.
- Reset asserted mid-count overrides all activity immediately, without waiting for a clock edge.
- Priority per rising edge: rst > load > en_in > hold.
- Load:
  - count <= load_val. If load_val >= MODULUS, count <= MODULUS-1 (clamp).
  - tc <= 0.
  - load overrides a simultaneous en_in; the enabled step is discarded, not deferred.
- Enabled, up_dn=1:
  - count < MODULUS-1: count <= count+1, tc <= 0.
  - count == MODULUS-1: count <= 0, tc <= 1.
- Enabled, up_dn=0:
  - count > 0: count <= count-1, tc <= 0.
  - count == 0: count <= MODULUS-1, tc <= 1.
- Idle (no load, en_in=0): count holds, tc <= 0. tc is therefore a single-cycle pulse, high in the cycle after the wrapping edge.
- Direction change takes effect on the next enabled edge. No extra latency and no glitch in count.
- Arithmetic:
  - Next-value logic is computed in WIDTH+1 bits so MODULUS = 2**WIDTH wraps correctly with no overflow.
  - Result is truncated to WIDTH.
- Latency:
  - count updates 1 cycle after the sampled en_in/load.
  - en_out has zero latency, so an N-stage chain advances in a single edge (synchronous, not ripple).
- WIDTH=1, MODULUS=2: behaves as a toggle flip-flop; at_term alternates each enabled edge.

Optional Feature:
- Macro: MOD_COUNTER_SAT_EN.
- Defined: saturating mode.
  - Up at MODULUS-1 holds; down at 0 holds.
  - tc pulses once on the edge that first reaches the bound, and does not pulse again while held.
  - en_out is forced to 0, so no cascade propagation.
- Undefined: wrap-around behaviour as above. The saturation logic is absent from the netlist.

Decomposition:
- Package counter_pkg holds:
  - typedef enum logic {DIR_DOWN=1'b0, DIR_UP=1'b1} dir_e.
  - function legal_modulus(width, modulus), used for the elaboration checks.
  - localparam MAX_WIDTH=32.
- One natural sub-module, mod_next_val: purely combinational.
  - Inputs: count, dir, at_term.
  - Outputs: next count and wrap flag.
  - Reused by the future multi-digit counter.
- The register, priority and tc logic live in mod_updown_counter.

Test Plan:
- WIDTH=4, MODULUS=10, rst=1 for 3 cycles, then en_in=1, up_dn=1 for 12 edges:
  - Sequence 0..9,0,1.
  - tc high only in the cycle after the 9->0 edge.
  - at_term=1 only while count=9.
- Down count: load 2, then en_in=1, up_dn=0 for 4 edges -> 2,1,0,9,8; tc pulses once after the 0->9 edge.
- Load clamp and priority:
  - load_val=13 with load=1 and en_in=1 -> count=9, tc=0.
  - load_val=5 -> count=5, no step applied.
- Async reset mid-count: assert rst between edges while count=7 -> count=0 immediately, before the next edge; tc=0.
- Cascade of two instances (units/tens), en_in=1 on units, 25 edges from reset:
  - tens=2, units=5.
  - Tens increments exactly on the edges where units wraps 9->0.
- Build with MOD_COUNTER_SAT_EN defined, count up 12 edges:
  - count sticks at 9.
  - tc pulses once.
  - en_out stays 0.
